// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick divider, raster counters and zero-skew registered sync/blank/fetch decode.
// Every output is registered from the position it will present, so all decoded outputs line up with x_pos/y_pos.
module vga_timing_gen #(
    parameter int PIX_DIV   = 4,
    parameter int H_AREA    = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_AREA    = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PREFETCH  = 2,
    localparam int H_TOTAL  = H_AREA + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_AREA + V_FP + V_SYNC + V_BP,
    localparam int XW       = $clog2(H_TOTAL),
    localparam int YW       = $clog2(V_TOTAL)
) (
    input  logic          CLK_40,
    input  logic          reset,
    input  logic          enable,
    output logic          pixel_en,
    output logic [XW-1:0] x_pos,
    output logic [YW-1:0] y_pos,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          fetch_en,
    output logic [XW-1:0] fetch_x,
    output logic [YW-1:0] fetch_y
);
    localparam int DW  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int XW1 = XW + 1;
    localparam int YW1 = YW + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    // PREFETCH < H_TOTAL, so the reset fetch point is either the reset pixel itself or on line 0.
    localparam logic [XW-1:0] FX_RST   = (PREFETCH == 0) ? X_LAST : XW'(PREFETCH - 1);
    localparam logic [YW-1:0] FY_RST   = (PREFETCH == 0) ? Y_LAST : YW'(0);
    localparam logic [XW:0]   HA  = XW1'(H_AREA);
    localparam logic [XW:0]   HS0 = XW1'(H_AREA + H_FP);
    localparam logic [XW:0]   HS1 = XW1'(H_AREA + H_FP + H_SYNC);
    localparam logic [YW:0]   VA  = YW1'(V_AREA);
    localparam logic [YW:0]   VS0 = YW1'(V_AREA + V_FP);
    localparam logic [YW:0]   VS1 = YW1'(V_AREA + V_FP + V_SYNC);

    logic [DW-1:0] div_q, div_d;
    logic [XW-1:0] x_q, x_d, fx_q, fx_d;
    logic [YW-1:0] y_q, y_d, fy_q, fy_d;
    logic          tick, hs_d, vs_d, act_d, fact_d;
    logic          pixel_en_q, hsync_q, vsync_q, blank_q, active_q;
    logic          line_start_q, frame_start_q, fetch_en_q;

    always_comb begin
        tick   = enable && (div_q == DIV_LAST);
        div_d  = tick ? '0 : div_q + 1'b1;
        x_d    = (x_q == X_LAST) ? '0 : x_q + 1'b1;
        y_d    = (x_q != X_LAST) ? y_q : (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        fx_d   = (fx_q == X_LAST) ? '0 : fx_q + 1'b1;
        fy_d   = (fx_q != X_LAST) ? fy_q : (fy_q == Y_LAST) ? '0 : fy_q + 1'b1;
        hs_d   = ({1'b0, x_d} >= HS0 && {1'b0, x_d} < HS1) ? HSYNC_POL : ~HSYNC_POL;
        vs_d   = ({1'b0, y_d} >= VS0 && {1'b0, y_d} < VS1) ? VSYNC_POL : ~VSYNC_POL;
        act_d  = ({1'b0, x_d} < HA) && ({1'b0, y_d} < VA);
        fact_d = ({1'b0, fx_d} < HA) && ({1'b0, fy_d} < VA);
    end

    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            fx_q          <= FX_RST;
            fy_q          <= FY_RST;
            pixel_en_q    <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            blank_q       <= 1'b1;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            fetch_en_q    <= 1'b0;
        end else begin
            pixel_en_q    <= tick;
            line_start_q  <= tick && (x_d == '0);
            frame_start_q <= tick && (x_d == '0) && (y_d == '0);
            fetch_en_q    <= tick && fact_d;
            if (enable)
                div_q <= div_d;
            if (tick) begin
                x_q      <= x_d;
                y_q      <= y_d;
                fx_q     <= fx_d;
                fy_q     <= fy_d;
                hsync_q  <= hs_d;
                vsync_q  <= vs_d;
                active_q <= act_d;
                blank_q  <= ~act_d;
            end
        end
    end

    assign pixel_en    = pixel_en_q;
    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign fetch_en    = fetch_en_q;
    assign fetch_x     = fx_q;
    assign fetch_y     = fy_q;
endmodule
